// File: rtl/jk_excite_pkg.sv
// Shared types and JK excitation table for the JK excite driver.
// The table is indexed by {cur, nxt}; a set Dc bit marks a don't-care that DC_MODE resolves.
package jk_excite_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StApply = 2'b01,
    StCheck = 2'b10
  } state_e;

  // Legal DC_MODE values: X resolves to hold/set/reset (0) or to toggle (1).
  localparam bit DcHold   = 1'b0;
  localparam bit DcToggle = 1'b1;

  localparam logic [3:0] ExcJVal = 4'b0010;
  localparam logic [3:0] ExcJDc  = 4'b1100;
  localparam logic [3:0] ExcKVal = 4'b0100;
  localparam logic [3:0] ExcKDc  = 4'b0011;

  function automatic logic exc_resolve(input logic [3:0] val, input logic [3:0] dc,
                                       input logic [1:0] idx, input bit dc_mode);
    return dc[idx] ? dc_mode : val[idx];
  endfunction

endpackage

// File: rtl/jk_excite_driver_if.sv
// Target handshake, JK drive and status bundle between the excite driver and its environment.
// master is the environment feeding targets and readback; slave is the driver itself.
interface jk_excite_driver_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) ();

  logic [WIDTH-1:0] tgt_data;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q_fb;
  logic             clear;
  logic             busy;
  logic             done_pulse;
  logic             err;
  logic [CNT_W-1:0] mismatch_cnt;

  modport master (
    output tgt_data, tgt_valid, q_fb, clear,
    input  tgt_ready, j, k, busy, done_pulse, err, mismatch_cnt
  );

  modport slave (
    input  tgt_data, tgt_valid, q_fb, clear,
    output tgt_ready, j, k, busy, done_pulse, err, mismatch_cnt
  );

endinterface

// File: rtl/jk_excite_lut.sv
// Per-bit JK excitation: given current and wanted next state, produce the J/K drive.
module jk_excite_lut
  import jk_excite_pkg::*;
#(
  parameter bit DC_MODE = DcHold
) (
  input  logic i_cur,
  input  logic i_nxt,
  output logic o_j,
  output logic o_k
);

  logic [1:0] w_idx;

  assign w_idx = {i_cur, i_nxt};
  assign o_j   = exc_resolve(ExcJVal, ExcJDc, w_idx, DC_MODE);
  assign o_k   = exc_resolve(ExcKVal, ExcKDc, w_idx, DC_MODE);

endmodule

// File: rtl/jk_excite_driver.sv
// Drives an external JK register towards requested targets and checks the readback.
// One transfer takes IDLE -> APPLY -> CHECK; model_q tracks what the register should hold.
module jk_excite_driver
  import jk_excite_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter bit          DC_MODE = DcHold,
  parameter int unsigned CNT_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  jk_excite_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_j, r_k, r_model_q, r_tgt;
  logic [WIDTH-1:0] w_j_lut, w_k_lut;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_mismatch;

  assign w_accept   = (r_state == StIdle) && bus.tgt_valid;
  assign w_mismatch = (r_state == StCheck) && (bus.q_fb != r_tgt);

  for (genvar g = 0; g < WIDTH; g++) begin : g_lut
    jk_excite_lut #(
      .DC_MODE(DC_MODE)
    ) u_lut (
      .i_cur(r_model_q[g]),
      .i_nxt(bus.tgt_data[g]),
      .o_j  (w_j_lut[g]),
      .o_k  (w_k_lut[g])
    );
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StApply;
      StApply: w_state_d = StCheck;
      StCheck: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_j       <= '0;
      r_k       <= '0;
      r_tgt     <= '0;
      r_model_q <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // J/K are live only during APPLY; every other cycle holds the external flops.
      r_j <= w_accept ? w_j_lut : '0;
      r_k <= w_accept ? w_k_lut : '0;
      if (w_accept) r_tgt <= bus.tgt_data;
      // Resync to what the register really holds so a mismatch does not cascade.
      if (r_state == StCheck) r_model_q <= bus.q_fb;
      if (bus.clear) begin
        r_err <= 1'b0;
        r_cnt <= '0;
      end else if (w_mismatch) begin
        r_err <= 1'b1;
        if (r_cnt != CntMax) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.j            = r_j;
  assign bus.k            = r_k;
  assign bus.tgt_ready    = (r_state == StIdle);
  assign bus.busy         = (r_state != StIdle);
  assign bus.done_pulse   = (r_state == StCheck);
  assign bus.err          = r_err;
  assign bus.mismatch_cnt = r_cnt;

endmodule
